tournament_predictor: RTL and testbench



---
 rtl/tournament_predictor.sv | 197 +++++++++++++++++++
 tb/tb_tournament_predictor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_predictor.sv
// tournament_predictor
//   Tournament direction predictor for the fetch stage. A per-PC local
//   history predictor and a gshare global predictor are arbitrated by a
//   per-PC chooser. The block owns the speculative global history register
//   (GHR), repairs it on a mispredict reported from EX, and clears every
//   table after reset with a one-entry-per-cycle sweep.
//
//   Ports
//     clk, rstn            clock, asynchronous active-low reset
//     ready                high once the post-reset table sweep is done
//     pred_valid, pc,
//     kind_pdc             prediction request (kind 1 = conditional,
//                          4..7 = unconditional, 0 = not a jump)
//     pred_out_valid       one-cycle pulse per accepted request
//     taken_pdc,
//     choice_pdc           predicted direction, 0 = local / 1 = global used
//     pdch                 {chooser, local, global} counters read
//     lh_pdc, gh_pdc       local history and GHR used for the prediction
//     update_en, pc_ex,
//     kind_ex, taken_real,
//     taken_pdc_ex,
//     pdch_ex, lh_ex, gh_ex  training from EX with the fetch-time snapshots
//
//   state | meaning
//   ------+------------------------------------------------------------
//   INIT  | sweeping all tables to their initial values, requests ignored
//   RUN   | predicting and training
module tournament_predictor #(
    parameter int ADDR_WIDTH = 30,
    parameter int PHT_IDX    = 10,
    parameter int LHT_IDX    = 8,
    parameter int GH_WIDTH   = 16,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     ready,
    input  logic                     pred_valid,
    input  logic [ADDR_WIDTH-1:0]    pc,
    input  logic [2:0]               kind_pdc,
    output logic                     pred_out_valid,
    output logic                     taken_pdc,
    output logic                     choice_pdc,
    output logic [3*CNT_WIDTH-1:0]   pdch,
    output logic [PHT_IDX-1:0]       lh_pdc,
    output logic [GH_WIDTH-1:0]      gh_pdc,
    input  logic                     update_en,
    input  logic [ADDR_WIDTH-1:0]    pc_ex,
    input  logic [2:0]               kind_ex,
    input  logic                     taken_real,
    input  logic                     taken_pdc_ex,
    input  logic [3*CNT_WIDTH-1:0]   pdch_ex,
    input  logic [PHT_IDX-1:0]       lh_ex,
    input  logic [GH_WIDTH-1:0]      gh_ex
);

    localparam int SWEEP_BITS = (PHT_IDX > LHT_IDX) ? PHT_IDX : LHT_IDX;
    localparam logic [SWEEP_BITS-1:0] SWEEP_LAST = '1;
    localparam logic [SWEEP_BITS-1:0] SWEEP_ONE  = SWEEP_BITS'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;
    // Weakest "not taken" value: MSB clear, remaining bits set (01 for 2 bits).
    localparam logic [CNT_WIDTH-1:0]  CNT_WEAK   = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    logic [SWEEP_BITS-1:0]   sweep_cnt;
    logic [GH_WIDTH-1:0]     ghr;

    logic [PHT_IDX-1:0]      lht  [2**LHT_IDX];
    logic [CNT_WIDTH-1:0]    lpht [2**PHT_IDX];
    logic [CNT_WIDTH-1:0]    gpht [2**PHT_IDX];
    logic [CNT_WIDTH-1:0]    cpht [2**PHT_IDX];

    function automatic logic [CNT_WIDTH-1:0] sat_step(input logic [CNT_WIDTH-1:0] v,
                                                      input logic up);
        logic [CNT_WIDTH-1:0] r;
        r = v;
        if (up) begin
            if (v != CNT_MAX) r = v + CNT_ONE;
        end else begin
            if (v != '0) r = v - CNT_ONE;
        end
        return r;
    endfunction

    // Prediction read path.
    logic [PHT_IDX-1:0]      lh_rd;
    logic [PHT_IDX-1:0]      gidx_rd;
    logic [CNT_WIDTH-1:0]    lcnt_rd;
    logic [CNT_WIDTH-1:0]    gcnt_rd;
    logic [CNT_WIDTH-1:0]    ccnt_rd;
    logic                    chosen;
    logic                    taken_nxt;
    logic                    accept;

    always_comb begin
        lh_rd     = lht[pc[LHT_IDX-1:0]];
        gidx_rd   = ghr[PHT_IDX-1:0] ^ pc[PHT_IDX-1:0];
        lcnt_rd   = lpht[lh_rd];
        gcnt_rd   = gpht[gidx_rd];
        ccnt_rd   = cpht[pc[PHT_IDX-1:0]];
        chosen    = ccnt_rd[CNT_WIDTH-1] ? gcnt_rd[CNT_WIDTH-1] : lcnt_rd[CNT_WIDTH-1];
        taken_nxt = kind_pdc[2] | ((kind_pdc == 3'd1) & chosen);
        accept    = (state == ST_RUN) & pred_valid;
    end

    // Training path: everything comes from the snapshots, no table re-read.
    logic [CNT_WIDTH-1:0]    ucnt_c;
    logic [CNT_WIDTH-1:0]    ucnt_l;
    logic [CNT_WIDTH-1:0]    ucnt_g;
    logic [PHT_IDX-1:0]      gidx_ex;
    logic                    do_upd;
    logic                    repair;
    logic                    disagree;

    always_comb begin
        ucnt_c   = pdch_ex[3*CNT_WIDTH-1:2*CNT_WIDTH];
        ucnt_l   = pdch_ex[2*CNT_WIDTH-1:CNT_WIDTH];
        ucnt_g   = pdch_ex[CNT_WIDTH-1:0];
        gidx_ex  = gh_ex[PHT_IDX-1:0] ^ pc_ex[PHT_IDX-1:0];
        do_upd   = (state == ST_RUN) & update_en & (kind_ex == 3'd1);
        repair   = do_upd & (taken_real != taken_pdc_ex);
        disagree = ucnt_l[CNT_WIDTH-1] != ucnt_g[CNT_WIDTH-1];
    end

    // Table storage has no reset; the INIT sweep clears it. When one table
    // is narrower than the sweep range its index simply wraps and the entry
    // is rewritten with the same value.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            lht[sweep_cnt[LHT_IDX-1:0]]  <= '0;
            lpht[sweep_cnt[PHT_IDX-1:0]] <= CNT_WEAK;
            gpht[sweep_cnt[PHT_IDX-1:0]] <= CNT_WEAK;
            cpht[sweep_cnt[PHT_IDX-1:0]] <= CNT_WEAK;
        end else if (do_upd) begin
            lpht[lh_ex]  <= sat_step(ucnt_l, taken_real);
            gpht[gidx_ex] <= sat_step(ucnt_g, taken_real);
            if (disagree) begin
                // Reward the chooser toward whichever side was right.
                cpht[pc_ex[PHT_IDX-1:0]] <= sat_step(ucnt_c, ucnt_g[CNT_WIDTH-1] == taken_real);
            end
            lht[pc_ex[LHT_IDX-1:0]] <= {lh_ex[PHT_IDX-2:0], taken_real};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_INIT;
            sweep_cnt      <= '0;
            ready          <= 1'b0;
            ghr            <= '0;
            pred_out_valid <= 1'b0;
            taken_pdc      <= 1'b0;
            choice_pdc     <= 1'b0;
            pdch           <= '0;
            lh_pdc         <= '0;
            gh_pdc         <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    pred_out_valid <= 1'b0;
                    sweep_cnt      <= sweep_cnt + SWEEP_ONE;
                    if (sweep_cnt == SWEEP_LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pred_out_valid <= accept;
                    if (accept) begin
                        taken_pdc  <= taken_nxt;
                        choice_pdc <= ccnt_rd[CNT_WIDTH-1];
                        pdch       <= {ccnt_rd, lcnt_rd, gcnt_rd};
                        lh_pdc     <= lh_rd;
                        gh_pdc     <= ghr;
                    end
                    // A repair overrides any speculative shift in the same cycle.
                    if (repair) begin
                        ghr <= {gh_ex[GH_WIDTH-2:0], taken_real};
                    end else if (accept && (kind_pdc == 3'd1)) begin
                        ghr <= {ghr[GH_WIDTH-2:0], taken_nxt};
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pc, pc_ex, gh_ex};

endmodule

// File: tb/tb_tournament_predictor.sv
// tb_tournament_predictor
//   Directed bench for tournament_predictor with PHT_IDX=4, LHT_IDX=3.
//   Requests push their hand-computed expected outputs into a queue; a
//   monitor pops and compares whenever pred_out_valid is seen.
module tb_tournament_predictor;

    localparam int AW = 30;
    localparam int PI = 4;
    localparam int LI = 3;
    localparam int GW = 16;
    localparam int CW = 2;

    logic            clk;
    logic            rstn;
    logic            ready;
    logic            pred_valid;
    logic [AW-1:0]   pc;
    logic [2:0]      kind_pdc;
    logic            pred_out_valid;
    logic            taken_pdc;
    logic            choice_pdc;
    logic [3*CW-1:0] pdch;
    logic [PI-1:0]   lh_pdc;
    logic [GW-1:0]   gh_pdc;
    logic            update_en;
    logic [AW-1:0]   pc_ex;
    logic [2:0]      kind_ex;
    logic            taken_real;
    logic            taken_pdc_ex;
    logic [3*CW-1:0] pdch_ex;
    logic [PI-1:0]   lh_ex;
    logic [GW-1:0]   gh_ex;

    tournament_predictor #(
        .ADDR_WIDTH (AW),
        .PHT_IDX    (PI),
        .LHT_IDX    (LI),
        .GH_WIDTH   (GW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pc             (pc),
        .kind_pdc       (kind_pdc),
        .pred_out_valid (pred_out_valid),
        .taken_pdc      (taken_pdc),
        .choice_pdc     (choice_pdc),
        .pdch           (pdch),
        .lh_pdc         (lh_pdc),
        .gh_pdc         (gh_pdc),
        .update_en      (update_en),
        .pc_ex          (pc_ex),
        .kind_ex        (kind_ex),
        .taken_real     (taken_real),
        .taken_pdc_ex   (taken_pdc_ex),
        .pdch_ex        (pdch_ex),
        .lh_ex          (lh_ex),
        .gh_ex          (gh_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            taken;
        logic            choice;
        logic [3*CW-1:0] pdch;
        logic [PI-1:0]   lh;
        logic [GW-1:0]   gh;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input string nm, input logic [AW-1:0] p, input logic [2:0] k,
                           input logic t, input logic c, input logic [3*CW-1:0] pd,
                           input logic [PI-1:0] l, input logic [GW-1:0] g);
        exp_t e;
        pred_valid = 1'b1;
        pc         = p;
        kind_pdc   = k;
        e.taken    = t;
        e.choice   = c;
        e.pdch     = pd;
        e.lh       = l;
        e.gh       = g;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_upd(input logic [AW-1:0] p, input logic [2:0] k, input logic tr,
                           input logic tp, input logic [3*CW-1:0] pd,
                           input logic [PI-1:0] l, input logic [GW-1:0] g);
        update_en    = 1'b1;
        pc_ex        = p;
        kind_ex      = k;
        taken_real   = tr;
        taken_pdc_ex = tp;
        pdch_ex      = pd;
        lh_ex        = l;
        gh_ex        = g;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        update_en  = 1'b0;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t  act;
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (pred_out_valid === 1'b1) begin
                act = {taken_pdc, choice_pdc, pdch, lh_pdc, gh_pdc};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pred_out_valid: got taken=%0b choice=%0b pdch=%b lh=%b gh=%h, required no output",
                             act.taken, act.choice, act.pdch, act.lh, act.gh);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL %s: got taken=%0b choice=%0b pdch=%b lh=%b gh=%h, required taken=%0b choice=%0b pdch=%b lh=%b gh=%h",
                                 nm, act.taken, act.choice, act.pdch, act.lh, act.gh,
                                 e.taken, e.choice, e.pdch, e.lh, e.gh);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rstn = 1'b0;
        idle();
        pc = '0; kind_pdc = '0;
        pc_ex = '0; kind_ex = '0; taken_real = 1'b0; taken_pdc_ex = 1'b0;
        pdch_ex = '0; lh_ex = '0; gh_ex = '0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 64'({ready, pred_out_valid, taken_pdc, choice_pdc, pdch, lh_pdc, gh_pdc}), 64'd0);

        // Release reset with a conditional request held high the whole sweep.
        @(negedge clk);
        rstn       = 1'b1;
        pred_valid = 1'b1;
        kind_pdc   = 3'd1;
        pc         = 30'd5;
        cyc = 0;
        for (int i = 1; i <= 40 && ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
        end
        pred_valid = 1'b0;
        check("ready_rise_cycle", 64'(cyc), 64'd16);
        check("ready_high", 64'(ready), 64'd1);

        @(negedge clk);
        set_req("p1_init_cond", 30'd5, 3'd1, 1'b0, 1'b0, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        set_req("p2_uncond", 30'd9, 3'd6, 1'b1, 1'b0, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        set_req("p3_notjump", 30'd3, 3'd0, 1'b0, 1'b0, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        idle();
        set_upd(30'd5, 3'd1, 1'b1, 1'b1, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        set_upd(30'd5, 3'd1, 1'b1, 1'b1, 6'b011010, 4'b0001, 16'h0000);
        @(negedge clk);
        set_upd(30'd2, 3'd1, 1'b1, 1'b1, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        // Non-conditional update with a direction mismatch: must be ignored.
        set_upd(30'd6, 3'd4, 1'b1, 1'b0, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        idle();
        @(negedge clk);

        // Back-to-back predictions; GHR shifts 0 -> 0 -> 1 -> 3.
        set_req("p4_lht5", 30'd5, 3'd1, 1'b0, 1'b0, 6'b010111, 4'b0011, 16'h0000);
        @(negedge clk);
        set_req("p5_lpht1", 30'd2, 3'd1, 1'b1, 1'b0, 6'b011110, 4'b0001, 16'h0000);
        @(negedge clk);
        set_req("p6_lpht0", 30'd6, 3'd1, 1'b1, 1'b0, 6'b011001, 4'b0000, 16'h0001);
        @(negedge clk);
        // Same-cycle repair and prediction: prediction sees old tables/GHR,
        // repair sets GHR to 1 and drops this request's shift.
        set_req("p7_repair_same_cycle", 30'd7, 3'd1, 1'b1, 1'b0, 6'b011001, 4'b0000, 16'h0003);
        set_upd(30'd4, 3'd1, 1'b1, 1'b0, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        idle();
        set_req("p8_after_repair", 30'd4, 3'd1, 1'b1, 1'b0, 6'b011111, 4'b0001, 16'h0001);
        @(negedge clk);
        idle();
        set_upd(30'd8, 3'd1, 1'b1, 1'b1, 6'b010011, 4'b1111, 16'h0000);
        @(negedge clk);
        idle();
        set_req("p9_chooser_inc", 30'd8, 3'd1, 1'b0, 1'b1, 6'b100101, 4'b1111, 16'h0003);
        @(negedge clk);
        idle();
        set_upd(30'd8, 3'd1, 1'b1, 1'b1, 6'b110011, 4'b1111, 16'h0000);
        @(negedge clk);
        idle();
        set_req("p10_chooser_sat_hi", 30'd8, 3'd1, 1'b0, 1'b1, 6'b110101, 4'b1111, 16'h0006);
        @(negedge clk);
        idle();
        set_upd(30'd9, 3'd1, 1'b0, 1'b0, 6'b000011, 4'b0111, 16'h0000);
        @(negedge clk);
        idle();
        set_req("p11_chooser_sat_lo", 30'd9, 3'd1, 1'b0, 1'b0, 6'b000111, 4'b1110, 16'h000C);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        check("queue_drained_run", 64'(exp_q.size()), 64'd0);

        // Mid-run reset: immediate return to reset values, full sweep again.
        rstn = 1'b0;
        #1;
        check("reset_mid_run", 64'({ready, pred_out_valid, taken_pdc, choice_pdc, pdch, lh_pdc, gh_pdc}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 40 && ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
        end
        check("ready_rise_after_rereset", 64'(cyc), 64'd16);
        @(negedge clk);
        set_req("p12_tables_cleared", 30'd5, 3'd1, 1'b0, 1'b0, 6'b010101, 4'b0000, 16'h0000);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        check("queue_drained_end", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
